// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the 23K640-style SPI SRAM responder.
// Opcodes, status-register mode encodings and the protocol FSM states.
package spi_sram_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRSR  = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        StCmd,
        StAddr,
        StRdData,
        StWrData,
        StRdsrData,
        StWrsrData,
        StIgnore
    } state_e;

    // Only the mode field and bit 0 are implemented; the rest read as zero.
    function automatic logic [7:0] status_pack(input logic [1:0] mode, input logic bit0);
        return {mode, 5'b0, bit0};
    endfunction

endpackage

// File: rtl/spi_sram_array.sv
// Byte-wide storage for the SRAM model: one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module spi_sram_array #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave model of a 23K640 serial SRAM, oversampling sck in the
// i_clk domain. Decodes READ/WRITE/RDSR/WRSR and reports each committed byte.
module spi_sram_responder
    import spi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned PAGE_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_cs,
    input  logic              i_si,
    output logic              o_so,
    output logic [1:0]        o_mode,
    output logic              o_wr_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data
);

    state_e            state_q, state_d;
    logic              sck_q;
    logic              rise;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              addr_lo_q, addr_lo_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        rx_q, rx_d, rx_next;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_shift, addr_adv, rd_addr;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        status_q, status_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              mem_we;
    logic [7:0]        rd_data;
    logic              byte_done;
    logic              byte_mode;

    // Page mode keeps the page bits and wraps the offset; sequential wraps the whole array.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [1:0]        mode);
        logic [ADDR_W-1:0] n;
        n = a + ADDR_W'(1);
        if (mode == MODE_PAGE) begin
            n = {a[ADDR_W-1:PAGE_W], n[PAGE_W-1:0]};
        end
        return n;
    endfunction

    assign rise       = i_sck & ~sck_q;
    assign rx_next    = {rx_q[6:0], i_si};
    assign addr_shift = {addr_q[ADDR_W-2:0], i_si};
    assign addr_adv   = next_addr(addr_q, status_q[7:6]);
    assign byte_done  = (bit_cnt_q == 3'd7);
    assign byte_mode  = !((status_q[7:6] == MODE_PAGE) || (status_q[7:6] == MODE_SEQ));
    // The only read during ADDR is the first data byte at the end of the address.
    assign rd_addr    = (state_q == StAddr) ? addr_shift : addr_adv;

    spi_sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (addr_q),
        .i_wdata (rx_next),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_lo_d  = addr_lo_q;
        is_wr_d    = is_wr_q;
        rx_d       = rx_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        status_d   = status_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;

        if (i_cs) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
            addr_lo_d = 1'b0;
        end else if (rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            unique case (state_q)
                StCmd: begin
                    if (byte_done) begin
                        addr_lo_d = 1'b0;
                        case (rx_next)
                            OP_READ: begin
                                is_wr_d = 1'b0;
                                state_d = StAddr;
                            end
                            OP_WRITE: begin
                                is_wr_d = 1'b1;
                                state_d = StAddr;
                            end
                            OP_RDSR: begin
                                tx_d    = status_q;
                                state_d = StRdsrData;
                            end
                            OP_WRSR: state_d = StWrsrData;
                            default: state_d = StIgnore;
                        endcase
                    end
                end
                StAddr: begin
                    addr_d = addr_shift;
                    if (byte_done) begin
                        addr_lo_d = 1'b1;
                        if (addr_lo_q) begin
                            if (is_wr_q) begin
                                state_d = StWrData;
                            end else begin
                                tx_d    = rd_data;
                                state_d = StRdData;
                            end
                        end
                    end
                end
                StRdData: begin
                    tx_d = {tx_q[6:0], 1'b0};
                    if (byte_done) begin
                        if (byte_mode) begin
                            state_d = StIgnore;
                        end else begin
                            addr_d = addr_adv;
                            tx_d   = rd_data;
                        end
                    end
                end
                StWrData: begin
                    if (byte_done) begin
                        mem_we     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = rx_next;
                        if (byte_mode) begin
                            state_d = StIgnore;
                        end else begin
                            addr_d = addr_adv;
                        end
                    end
                end
                StRdsrData: begin
                    tx_d = byte_done ? status_q : {tx_q[6:0], 1'b0};
                end
                StWrsrData: begin
                    if (byte_done) begin
                        status_d = status_pack(rx_next[7:6], rx_next[0]);
                        state_d  = StIgnore;
                    end
                end
                StIgnore: ;
                default: state_d = StCmd;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StCmd;
            sck_q      <= 1'b0;
            bit_cnt_q  <= 3'd0;
            addr_lo_q  <= 1'b0;
            is_wr_q    <= 1'b0;
            rx_q       <= 8'h00;
            addr_q     <= '0;
            tx_q       <= 8'h00;
            status_q   <= 8'h00;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            sck_q      <= i_sck;
            bit_cnt_q  <= bit_cnt_d;
            addr_lo_q  <= addr_lo_d;
            is_wr_q    <= is_wr_d;
            rx_q       <= rx_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            status_q   <= status_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign o_so       = ((state_q == StRdData) || (state_q == StRdsrData)) ? tx_q[7] : 1'b0;
    assign o_mode     = status_q[7:6];
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: an SPI master drives transactions while a
// byte-array model predicts commits, read data, status and mode.
module tb_spi_sram_responder;

    localparam int ADDR_W = 13;
    localparam int PAGE_W = 5;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_sck = 1'b0;
    logic              i_cs  = 1'b1;
    logic              i_si  = 1'b0;
    logic              o_so;
    logic [1:0]        o_mode;
    logic              o_wr_valid;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;

    spi_sram_responder #(
        .ADDR_W (ADDR_W),
        .PAGE_W (PAGE_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_sck      (i_sck),
        .i_cs       (i_cs),
        .i_si       (i_si),
        .o_so       (o_so),
        .o_mode     (o_mode),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [7:0]  m_mem [8192];
    logic [1:0]  m_mode   = 2'b00;
    logic [7:0]  m_status = 8'h00;
    logic [20:0] exp_q [$];
    logic [20:0] seen_q [$];
    logic [7:0]  rd_buf [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] m_next(input logic [12:0] a, input logic [1:0] mode);
        int v;
        v = int'(a);
        if (mode == 2'b10) v = (v / 32) * 32 + ((v % 32) + 1) % 32;
        else               v = (v + 1) % 8192;
        return 13'(v);
    endfunction

    function automatic bit m_streams(input logic [1:0] mode);
        return (mode == 2'b10) || (mode == 2'b01);
    endfunction

    // Compare process: commits against the model queue, idle outputs against the model.
    always @(posedge i_clk) begin
        #2;
        if (!i_rst) begin
            if (o_wr_valid) begin
                seen_q.push_back({o_wr_addr, o_wr_data});
                if (exp_q.size() == 0) check("wr_unexpected", 32'(o_wr_addr), 32'hFFFF);
                else check("wr_commit", 32'({o_wr_addr, o_wr_data}), 32'(exp_q.pop_front()));
            end
            if (i_cs) begin
                check("idle_mode", 32'(o_mode), 32'(m_mode));
                check("idle_so", 32'(o_so), 32'h0);
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b > 7 - nbits; b--) begin
            i_si = tx[b];
            clk_n(2);
            rx[b] = o_so;
            i_sck = 1'b1;
            clk_n(2);
            i_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_lo();
        i_cs = 1'b0;
        clk_n(2);
    endtask

    task automatic cs_hi();
        clk_n(2);
        i_cs = 1'b1;
        i_si = 1'b0;
        clk_n(3);
    endtask

    task automatic do_wrsr(input logic [7:0] v);
        logic [7:0] r;
        cs_lo();
        spi_byte(8'h01, r);
        spi_byte(v, r);
        m_mode   = v[7:6];
        m_status = {v[7:6], 5'b0, v[0]};
        cs_hi();
    endtask

    task automatic do_rdsr(input int n);
        logic [7:0] r;
        cs_lo();
        spi_byte(8'h05, r);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, r);
            rd_buf[i] = r;
            check("rdsr_byte", 32'(r), 32'(m_status));
        end
        cs_hi();
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2, input int n);
        logic [7:0]  d [3];
        logic [12:0] a;
        logic [7:0]  r;
        d[0] = d0; d[1] = d1; d[2] = d2;
        a = addr[12:0];
        cs_lo();
        spi_byte(8'h02, r);
        spi_byte(addr[15:8], r);
        spi_byte(addr[7:0], r);
        for (int i = 0; i < n; i++) begin
            if (i == 0 || m_streams(m_mode)) begin
                exp_q.push_back({a, d[i]});
                m_mem[a] = d[i];
                a = m_next(a, m_mode);
            end
            spi_byte(d[i], r);
        end
        cs_hi();
    endtask

    task automatic do_read(input logic [15:0] addr, input int n);
        logic [12:0] a;
        logic [7:0]  r;
        logic [7:0]  e;
        a = addr[12:0];
        cs_lo();
        spi_byte(8'h03, r);
        spi_byte(addr[15:8], r);
        spi_byte(addr[7:0], r);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, r);
            rd_buf[i] = r;
            e = (i > 0 && !m_streams(m_mode)) ? 8'h00 : m_mem[a];
            check("rd_data", 32'(r), 32'(e));
            if (m_streams(m_mode)) a = m_next(a, m_mode);
        end
        cs_hi();
    endtask

    initial begin
        logic [7:0] r;
        int         n;

        // Reset values
        clk_n(3);
        check("rst_so", 32'(o_so), 32'h0);
        check("rst_wr_valid", 32'(o_wr_valid), 32'h0);
        check("rst_wr_addr", 32'(o_wr_addr), 32'h0);
        check("rst_wr_data", 32'(o_wr_data), 32'h0);
        check("rst_mode", 32'(o_mode), 32'h0);
        i_rst = 1'b0;
        clk_n(3);

        // Status write/read, sequential mode
        do_wrsr(8'h41);
        do_rdsr(2);
        check("rdsr_lit0", 32'(rd_buf[0]), 32'h41);
        check("rdsr_lit1", 32'(rd_buf[1]), 32'h41);
        check("mode_seq_lit", 32'(o_mode), 32'h1);

        // Byte mode: extra data byte is ignored, extra read bytes are zero
        do_wrsr(8'h00);
        do_write(16'h0123, 8'hA5, 8'h5A, 8'h00, 2);
        n = seen_q.size();
        check("byte_commit_lit", 32'(seen_q[n-1]), 32'({13'h0123, 8'hA5}));
        do_read(16'h0123, 3);
        check("byte_rd_lit0", 32'(rd_buf[0]), 32'hA5);
        check("byte_rd_lit1", 32'(rd_buf[1]), 32'h00);
        check("byte_rd_lit2", 32'(rd_buf[2]), 32'h00);

        // Sequential mode with wrap at the top of the array
        do_wrsr(8'h40);
        do_write(16'h1FFE, 8'h11, 8'h22, 8'h33, 3);
        n = seen_q.size();
        check("seq_addr0_lit", 32'(seen_q[n-3][20:8]), 32'h1FFE);
        check("seq_addr1_lit", 32'(seen_q[n-2][20:8]), 32'h1FFF);
        check("seq_addr2_lit", 32'(seen_q[n-1][20:8]), 32'h0000);
        do_read(16'h1FFE, 3);
        check("seq_rd_lit0", 32'(rd_buf[0]), 32'h11);
        check("seq_rd_lit1", 32'(rd_buf[1]), 32'h22);
        check("seq_rd_lit2", 32'(rd_buf[2]), 32'h33);

        // Page mode with wrap inside the 32-byte page; upper address bits ignored
        do_wrsr(8'h80);
        do_write(16'hE03E, 8'hAA, 8'hBB, 8'hCC, 3);
        n = seen_q.size();
        check("page_addr0_lit", 32'(seen_q[n-3][20:8]), 32'h003E);
        check("page_addr1_lit", 32'(seen_q[n-2][20:8]), 32'h003F);
        check("page_addr2_lit", 32'(seen_q[n-1][20:8]), 32'h0020);
        do_read(16'h003E, 3);

        // Aborted write: 5 data bits then CS high
        cs_lo();
        spi_byte(8'h02, r);
        spi_byte(8'h01, r);
        spi_byte(8'h23, r);
        spi_bits(8'hFF, 5, r);
        cs_hi();
        do_read(16'h0123, 1);
        check("abort_keep_lit", 32'(rd_buf[0]), 32'hA5);
        do_rdsr(1);

        // Unknown opcode: so stays low for the rest of the frame
        cs_lo();
        spi_byte(8'h9F, r);
        spi_byte(8'h00, r);
        check("ignore_so0", 32'(r), 32'h0);
        spi_byte(8'hFF, r);
        check("ignore_so1", 32'(r), 32'h0);
        cs_hi();
        do_rdsr(1);

        // Reset in the middle of a page-mode read
        cs_lo();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h20, r);
        spi_bits(8'h00, 4, r);
        check("pre_rst_bits", 32'(r[7:4]), 32'hC);
        i_rst = 1'b1;
        m_mode   = 2'b00;
        m_status = 8'h00;
        clk_n(1);
        check("midrst_so", 32'(o_so), 32'h0);
        check("midrst_mode", 32'(o_mode), 32'h0);
        check("midrst_wr_valid", 32'(o_wr_valid), 32'h0);
        clk_n(1);
        i_rst = 1'b0;
        clk_n(1);
        spi_byte(8'h00, r);
        check("postrst_so0", 32'(r), 32'h0);
        spi_byte(8'h00, r);
        check("postrst_so1", 32'(r), 32'h0);
        cs_hi();
        do_read(16'h003E, 1);
        check("retain_lit0", 32'(rd_buf[0]), 32'hAA);
        do_read(16'h1FFF, 1);
        check("retain_lit1", 32'(rd_buf[0]), 32'h22);
        do_read(16'h0020, 1);
        check("retain_lit2", 32'(rd_buf[0]), 32'hCC);

        clk_n(4);
        check("pending_commits", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
